// File: rtl/dma_pkg.sv
// Shared DMA definitions used by the data-path blocks:
// state encoding, full byte-enable and the Avalon word size.
package dma_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } dma_state_e;

    localparam logic [3:0] BE_FULL    = 4'hF;
    localparam int         WORD_BYTES = 4;

endpackage

// File: rtl/dma_write_master.sv
// Drain side of the DMA data path: pops words from a show-ahead FIFO and
// writes them over an Avalon-MM write master to consecutive word addresses.
module dma_write_master
    import dma_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic              iClk,
    input  logic              iReset_n,
    input  logic              iStart,
    input  logic [ADDR_W-1:0] iDstAddr,
    input  logic [LEN_W-1:0]  iLength,
    input  logic              iAbort,
    output logic              oBusy,
    output logic              oDone,
    output logic              oAborted,
    output logic              FF_readrequest,
    input  logic [31:0]       FF_q,
    input  logic              FF_empty,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_write,
    output logic [31:0]       avm_writedata,
    output logic [3:0]        avm_byteenable,
    input  logic              avm_waitrequest
);

    localparam int CNT_W = LEN_W - 2;

    dma_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  words_q, words_d;
    logic              aborted_q, aborted_d;
    logic              abortPend_q, abortPend_d;

    logic              beatAccept;
    logic              beatStalled;
    logic              abortReq;
    logic [CNT_W-1:0]  startWords;
    logic              unusedBits;

    // Byte-offset bits of address and length carry no meaning for word transfers.
    assign unusedBits  = ^{iDstAddr[1:0], iLength[1:0]};
    assign startWords  = iLength[LEN_W-1:2];

    assign avm_write   = (state_q == WRITE) && !FF_empty;
    assign beatAccept  = avm_write && !avm_waitrequest;
    assign beatStalled = avm_write && avm_waitrequest;
    assign abortReq    = abortPend_q || iAbort;

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            words_q     <= '0;
            aborted_q   <= 1'b0;
            abortPend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            words_q     <= words_d;
            aborted_q   <= aborted_d;
            abortPend_q <= abortPend_d;
        end
    end

    // A stalled beat must finish before an abort may take effect, and an
    // abort that lands on the final beat is reported as a normal completion.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        words_d     = words_q;
        aborted_d   = aborted_q;
        abortPend_d = abortPend_q;

        case (state_q)
            IDLE: begin
                if (iStart) begin
                    addr_d    = {iDstAddr[ADDR_W-1:2], 2'b00};
                    words_d   = startWords;
                    aborted_d = 1'b0;
                    state_d   = (startWords == '0) ? DONE : WRITE;
                end
            end

            WRITE: begin
                if (iAbort) begin
                    abortPend_d = 1'b1;
                end
                if (beatAccept) begin
                    addr_d  = addr_q + ADDR_W'(WORD_BYTES);
                    words_d = words_q - CNT_W'(1);
                end
                if (beatAccept && (words_q == CNT_W'(1))) begin
                    state_d = DONE;
                end else if (abortReq && !beatStalled) begin
                    state_d   = DONE;
                    aborted_d = 1'b1;
                end
            end

            DONE: begin
                abortPend_d = 1'b0;
                state_d     = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign oBusy          = (state_q == WRITE) || (state_q == DONE);
    assign oDone          = (state_q == DONE);
    assign oAborted       = aborted_q;
    assign FF_readrequest = beatAccept;
    assign avm_address    = addr_q;
    assign avm_writedata  = FF_q;
    assign avm_byteenable = BE_FULL;

endmodule
